// File: rtl/micalog_counter_pkg.sv
// Shared definitions for the micalog counter family: limit-handling mode
// constants and the clamp helper used when loading a new count value.
package micalog_counter_pkg;

   localparam int COUNT_WRAP     = 0;
   localparam int COUNT_SATURATE = 1;

   // Force value into [lo, hi]; operands are carried at 32 bits so any
   // counter width up to 32 can share one helper.
   function automatic logic [31:0] clamp(
      input logic [31:0] value,
      input logic [31:0] lo,
      input logic [31:0] hi
   );
      if (value > hi) begin
         clamp = hi;
      end else if (value < lo) begin
         clamp = lo;
      end else begin
         clamp = value;
      end
   endfunction

endpackage

// File: rtl/prescaled_up_down_counter_prescaler.sv
// Count-enable prescaler: emits one tick for every PRESCALE enabled cycles.
// With PRESCALE = 1 there is no phase register and tick follows enable.
module prescaler #(
   parameter int PRESCALE = 1
) (
   input  logic clock,
   input  logic reset_,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   generate
      if (PRESCALE == 1) begin : g_bypass
         logic unused_ctrl;
         assign unused_ctrl = ^{clock, reset_, clear};
         assign tick        = enable;
      end else begin : g_div
         localparam int            PW   = $clog2(PRESCALE);
         localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

         logic [PW-1:0] phase_q;

         assign tick = enable && (phase_q == LAST);

         // Phase counter: advances on enabled cycles, restarts after a tick,
         // and discards any partial phase on reset or an external clear.
         always_ff @(posedge clock) begin
            if (reset_ || clear) begin
               phase_q <= '0;
            end else if (enable) begin
               phase_q <= tick ? '0 : phase_q + PW'(1);
            end
         end
      end
   endgenerate

endmodule

// File: rtl/prescaled_up_down_counter.sv
// Range-limited up/down counter with wrap or saturate behaviour at the
// limits, a count-enable prescaler, a clamped load port and boundary flags.
module prescaled_up_down_counter
   import micalog_counter_pkg::*;
#(
   parameter int               WIDTH       = 16,
   parameter logic [WIDTH-1:0] LIMIT_LO    = '0,
   parameter logic [WIDTH-1:0] LIMIT_HI    = {WIDTH{1'b1}},
   parameter int               SATURATE    = COUNT_WRAP,
   parameter int               PRESCALE    = 1,
   parameter logic [WIDTH-1:0] RESET_VALUE = LIMIT_LO
) (
   input  logic             clock,
   input  logic             reset_,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             enable,
   input  logic             up,
   output logic [WIDTH-1:0] count,
   output logic             at_max,
   output logic             at_min,
   output logic             boundary
);

   localparam bit SAT_MODE = (SATURATE == COUNT_SATURATE);

   logic             tick;
   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_nxt;
   logic             boundary_q;
   logic             boundary_nxt;

   // A load restarts the prescale phase so the next step needs a full
   // PRESCALE enabled cycles.
   prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clock  (clock),
      .reset_ (reset_),
      .clear  (load),
      .enable (enable),
      .tick   (tick)
   );

   // Next count: load beats tick; limits are compared before stepping so
   // no carry or borrow out of WIDTH bits is ever needed.
   always_comb begin
      count_nxt    = count_q;
      boundary_nxt = 1'b0;
      if (load) begin
         count_nxt = WIDTH'(clamp(32'(load_value), 32'(LIMIT_LO), 32'(LIMIT_HI)));
      end else if (tick) begin
         if (up) begin
            if (count_q == LIMIT_HI) begin
               boundary_nxt = 1'b1;
               count_nxt    = SAT_MODE ? LIMIT_HI : LIMIT_LO;
            end else begin
               count_nxt = count_q + WIDTH'(1);
            end
         end else begin
            if (count_q == LIMIT_LO) begin
               boundary_nxt = 1'b1;
               count_nxt    = SAT_MODE ? LIMIT_LO : LIMIT_HI;
            end else begin
               count_nxt = count_q - WIDTH'(1);
            end
         end
      end
   end

   // Count and boundary-pulse registers.
   always_ff @(posedge clock) begin
      if (reset_) begin
         count_q    <= RESET_VALUE;
         boundary_q <= 1'b0;
      end else begin
         count_q    <= count_nxt;
         boundary_q <= boundary_nxt;
      end
   end

   assign count    = count_q;
   assign boundary = boundary_q;
   assign at_max   = (count_q == LIMIT_HI);
   assign at_min   = (count_q == LIMIT_LO);

endmodule

// File: tb/tb_prescaled_up_down_counter.sv
// Directed bench for prescaled_up_down_counter: four parameterisations run
// side by side; expected outputs are queued as stimulus is applied and
// compared one edge later.
module tb_prescaled_up_down_counter;

   typedef struct {
      int          id;
      string       tag;
      logic [7:0]  cnt;
      logic        bnd;
   } exp_t;

   logic       clock = 1'b0;
   logic       rst [4];
   logic       ld  [4];
   logic       en  [4];
   logic       dir [4];
   logic [7:0] lv  [4];

   logic [3:0] cnt_a, cnt_b, cnt_c;
   logic [7:0] cnt_d;
   logic       mx [4];
   logic       mn [4];
   logic       bd [4];

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   int lim_lo [4] = '{0, 3, 0, 0};
   int lim_hi [4] = '{15, 10, 10, 255};

   always #5 clock = ~clock;

   // 4-bit full range, wrap
   prescaled_up_down_counter #(.WIDTH(4)) u_a (
      .clock(clock), .reset_(rst[0]), .load(ld[0]), .load_value(lv[0][3:0]),
      .enable(en[0]), .up(dir[0]), .count(cnt_a), .at_max(mx[0]), .at_min(mn[0]),
      .boundary(bd[0]));

   // [3,10], saturate
   prescaled_up_down_counter #(.WIDTH(4), .LIMIT_LO(4'd3), .LIMIT_HI(4'd10),
      .SATURATE(1)) u_b (
      .clock(clock), .reset_(rst[1]), .load(ld[1]), .load_value(lv[1][3:0]),
      .enable(en[1]), .up(dir[1]), .count(cnt_b), .at_max(mx[1]), .at_min(mn[1]),
      .boundary(bd[1]));

   // [0,10], wrap, prescale 4
   prescaled_up_down_counter #(.WIDTH(4), .LIMIT_HI(4'd10), .PRESCALE(4)) u_c (
      .clock(clock), .reset_(rst[2]), .load(ld[2]), .load_value(lv[2][3:0]),
      .enable(en[2]), .up(dir[2]), .count(cnt_c), .at_max(mx[2]), .at_min(mn[2]),
      .boundary(bd[2]));

   // 8-bit full range, wrap
   prescaled_up_down_counter #(.WIDTH(8)) u_d (
      .clock(clock), .reset_(rst[3]), .load(ld[3]), .load_value(lv[3]),
      .enable(en[3]), .up(dir[3]), .count(cnt_d), .at_max(mx[3]), .at_min(mn[3]),
      .boundary(bd[3]));

   task automatic push(input int id, input string tag, input int c, input logic b);
      exp_t e;
      e.id  = id;
      e.tag = tag;
      e.cnt = 8'(c);
      e.bnd = b;
      sb.push_back(e);
   endtask

   task automatic check(input string tag, input int obs, input int expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // Advance one edge, then compare every queued expectation.
   task automatic cyc();
      exp_t e;
      int   c;
      @(posedge clock);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         case (e.id)
            0:       c = int'(cnt_a);
            1:       c = int'(cnt_b);
            2:       c = int'(cnt_c);
            default: c = int'(cnt_d);
         endcase
         check({e.tag, "_count"}, c, int'(e.cnt));
         check({e.tag, "_at_max"}, int'(mx[e.id]), int'(int'(e.cnt) == lim_hi[e.id]));
         check({e.tag, "_at_min"}, int'(mn[e.id]), int'(int'(e.cnt) == lim_lo[e.id]));
         check({e.tag, "_boundary"}, int'(bd[e.id]), int'(e.bnd));
      end
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         rst[i] = 1'b1; ld[i] = 1'b0; en[i] = 1'b0; dir[i] = 1'b1; lv[i] = 8'd0;
      end
      // Reset state of every instance
      push(0, "rst_a", 0, 1'b0);
      push(1, "rst_b", 3, 1'b0);
      push(2, "rst_c", 0, 1'b0);
      push(3, "rst_d", 0, 1'b0);
      cyc();
      for (int i = 0; i < 4; i++) rst[i] = 1'b0;

      // Wrap up: 15 steps to the top, 16th wraps with a pulse
      en[0] = 1'b1; dir[0] = 1'b1;
      for (int i = 1; i <= 15; i++) begin
         push(0, "wrap_up", i, 1'b0);
         cyc();
      end
      push(0, "wrap_lo", 0, 1'b1);
      cyc();
      en[0] = 1'b0;
      push(0, "wrap_idle", 0, 1'b0);
      cyc();

      // Saturate down: load 4, three down ticks
      ld[1] = 1'b1; lv[1] = 8'd4;
      push(1, "sat_ld4", 4, 1'b0);
      cyc();
      ld[1] = 1'b0; en[1] = 1'b1; dir[1] = 1'b0;
      push(1, "sat_dn1", 3, 1'b0);
      cyc();
      push(1, "sat_dn2", 3, 1'b1);
      cyc();
      push(1, "sat_dn3", 3, 1'b1);
      cyc();
      en[1] = 1'b0;
      push(1, "sat_idle", 3, 1'b0);
      cyc();
      // Saturate up at 10, clamp of a low load
      ld[1] = 1'b1; lv[1] = 8'd9;
      push(1, "sat_ld9", 9, 1'b0);
      cyc();
      ld[1] = 1'b0; en[1] = 1'b1; dir[1] = 1'b1;
      push(1, "sat_up1", 10, 1'b0);
      cyc();
      push(1, "sat_up2", 10, 1'b1);
      cyc();
      en[1] = 1'b0; ld[1] = 1'b1; lv[1] = 8'd1;
      push(1, "clamp_lo", 3, 1'b0);
      cyc();
      ld[1] = 1'b0;

      // Prescale by 4: 8 enabled, 2 idle, 4 enabled
      en[2] = 1'b1; dir[2] = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         push(2, "pre_run", k / 4, 1'b0);
         cyc();
      end
      en[2] = 1'b0;
      for (int k = 0; k < 2; k++) begin
         push(2, "pre_hold", 2, 1'b0);
         cyc();
      end
      en[2] = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         push(2, "pre_resume", (k == 4) ? 3 : 2, 1'b0);
         cyc();
      end

      // Load on a tick cycle: clamp to 10, no pulse, phase restarts
      for (int k = 0; k < 3; k++) begin
         push(2, "ldp_phase", 3, 1'b0);
         cyc();
      end
      ld[2] = 1'b1; lv[2] = 8'd14;
      push(2, "ldp_clamp", 10, 1'b0);
      cyc();
      ld[2] = 1'b0;
      for (int k = 0; k < 3; k++) begin
         push(2, "ldp_wait", 10, 1'b0);
         cyc();
      end
      push(2, "ldp_wrap", 0, 1'b1);
      cyc();
      en[2] = 1'b0;
      push(2, "ldp_idle", 0, 1'b0);
      cyc();

      // Reset mid-prescale: count 7, phase 2 of 4
      ld[2] = 1'b1; lv[2] = 8'd7;
      push(2, "rmid_ld7", 7, 1'b0);
      cyc();
      ld[2] = 1'b0; en[2] = 1'b1;
      for (int k = 0; k < 2; k++) begin
         push(2, "rmid_phase", 7, 1'b0);
         cyc();
      end
      rst[2] = 1'b1;
      push(2, "rmid_rst", 0, 1'b0);
      cyc();
      rst[2] = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         push(2, "rmid_after", (k == 4) ? 1 : 0, 1'b0);
         cyc();
      end
      en[2] = 1'b0;

      // Direction change on an 8-bit full-range counter
      en[3] = 1'b1; dir[3] = 1'b0;
      push(3, "dir_dn_wrap", 255, 1'b1);
      cyc();
      dir[3] = 1'b1;
      push(3, "dir_up_wrap", 0, 1'b1);
      cyc();
      push(3, "dir_up_step", 1, 1'b0);
      cyc();
      en[3] = 1'b0;
      push(3, "dir_idle", 1, 1'b0);
      cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
